// File: rtl/zc_spi_pkg.sv
// rtl/zc_spi_pkg.sv - shared state encoding and idle/reset constants for the SD SPI master
package zc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_FIN
  } spi_state_e;

  localparam logic       SPI_IDLE_MOSI = 1'b1;
  localparam logic [7:0] RX_RESET      = 8'hFF;

endpackage

// File: rtl/zc_spi_master_half_tick.sv
// rtl/zc_spi_master_half_tick.sv - loadable down-counter that flags the end of an SPI half-period
module spi_half_tick #(
  parameter int W = 7
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Loading div-1 makes a phase last exactly div cycles; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/zc_spi_master.sv
// rtl/zc_spi_master.sv - byte-wide SPI mode-0 initiator for the SD card link
module zc_spi_master
  import zc_spi_pkg::*;
#(
  parameter int FAST_DIV = 2,
  parameter int SLOW_DIV = 64
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cs_wr,
  input  logic       cs_val,
  input  logic       slow,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       done,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso,
  output logic       sd_cs_n
);

  localparam int DW = $clog2(SLOW_DIV + 1);
  localparam logic [DW-1:0] FAST_V = DW'(FAST_DIV);
  localparam logic [DW-1:0] SLOW_V = DW'(SLOW_DIV);

  spi_state_e    state_q, state_d;
  logic [7:0]    tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic [2:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d, load_div;
  logic          sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic          pend_v_q, pend_v_d, pend_q, pend_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          load, tick;

  spi_half_tick #(.W(DW)) u_half_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load_i  (load),
    .div_i   (load_div),
    .tick_o  (tick)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    bit_d    = bit_q;
    div_d    = div_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_div = div_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_wr) cs_n_d = cs_val;
        if (start) begin
          div_d    = slow ? SLOW_V : FAST_V;
          load_div = div_d;
          load     = 1'b1;
          tx_d     = tx_byte;
          mosi_d   = tx_byte[7];
          bit_d    = 3'd7;
          busy_d   = 1'b1;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tick) begin
          load    = 1'b1;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], sd_miso};
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_q == 3'd0) begin
            state_d = ST_FIN;
          end else begin
            load    = 1'b1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            bit_d   = bit_q - 3'd1;
            state_d = ST_LOW;
          end
        end
      end
      ST_FIN: begin
        rx_d     = rx_sh_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        mosi_d   = SPI_IDLE_MOSI;
        pend_v_d = 1'b0;
        state_d  = ST_IDLE;
        // A write landing in this very cycle is the newest value, so it beats the pending one.
        if (cs_wr) begin
          cs_n_d = cs_val;
        end else if (pend_v_q) begin
          cs_n_d = pend_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cs_wr && (state_q == ST_LOW || state_q == ST_HIGH)) begin
      pend_v_d = 1'b1;
      pend_d   = cs_val;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tx_q     <= '0;
      rx_sh_q  <= '0;
      rx_q     <= RX_RESET;
      bit_q    <= '0;
      div_q    <= FAST_V;
      sclk_q   <= 1'b0;
      mosi_q   <= SPI_IDLE_MOSI;
      cs_n_q   <= 1'b1;
      pend_v_q <= 1'b0;
      pend_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      rx_sh_q  <= rx_sh_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rx_byte = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sd_clk  = sclk_q;
  assign sd_mosi = mosi_q;
  assign sd_cs_n = cs_n_q;

endmodule

// File: tb/tb_zc_spi_master.sv
// tb/tb_zc_spi_master.sv - randomized bench for zc_spi_master with a cycle-timing reference model
module tb_zc_spi_master;

  localparam int FAST_DIV = 2;
  localparam int SLOW_DIV = 64;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_wr   = 1'b0;
  logic       cs_val  = 1'b1;
  logic       slow    = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] rx_byte;
  logic       busy, done, sd_clk, sd_mosi, sd_miso, sd_cs_n;

  zc_spi_master #(.FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .cs_wr   (cs_wr),
    .cs_val  (cs_val),
    .slow    (slow),
    .start   (start),
    .tx_byte (tx_byte),
    .rx_byte (rx_byte),
    .busy    (busy),
    .done    (done),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso),
    .sd_cs_n (sd_cs_n)
  );

  always #5 clk_sys = ~clk_sys;

  // Far-end device: 0 loopback, 1 tied low, 2 fixed random byte, 3 SD card answering CMD0.
  int          miso_mode = 0;
  logic [7:0]  rand_out  = 8'h00;
  logic [7:0]  card_out  = 8'hFF;
  logic [7:0]  slv_in    = 8'h00;
  logic [47:0] slv_hist  = '0;
  int          slv_bit   = 0;
  int          slv_rises = 0;

  always @(posedge sd_clk or negedge reset_n) begin
    if (!reset_n) begin
      slv_bit <= 0;
    end else begin
      slv_in    <= {slv_in[6:0], sd_mosi};
      slv_rises <= slv_rises + 1;
      if (slv_bit == 7) begin
        slv_bit  <= 0;
        slv_hist <= {slv_hist[39:0], slv_in[6:0], sd_mosi};
        card_out <= (!sd_cs_n && {slv_hist[39:0], slv_in[6:0], sd_mosi} == 48'h400000000095)
                    ? 8'h01 : 8'hFF;
      end else begin
        slv_bit <= slv_bit + 1;
      end
    end
  end

  always_comb begin
    case (miso_mode)
      0:       sd_miso = sd_mosi;
      1:       sd_miso = 1'b0;
      2:       sd_miso = rand_out[7 - slv_bit];
      default: sd_miso = card_out[7 - slv_bit];
    endcase
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: one accepted byte occupies cycles start+1 .. start+16*div+1, done at +16*div+2.
  logic       m_act = 1'b0;
  int         m_st  = 0;
  int         m_div = FAST_DIV;
  logic [7:0] m_tx  = 8'h00;
  logic [7:0] m_exp = 8'hFF;
  logic [7:0] m_rx  = 8'hFF;
  logic       m_cs  = 1'b1;
  logic       m_pv  = 1'b0;
  logic       m_pval = 1'b1;
  logic       seen_done = 1'b0;
  logic       cs_smp = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic cycle();
    int   k, idx;
    logic e_busy, e_done, e_clk, e_mosi;
    @(negedge clk_sys);
    k      = m_act ? (cyc - m_st) : -1;
    e_busy = m_act && k >= 1 && k <= 16 * m_div + 1;
    e_done = m_act && k == 16 * m_div + 2;
    e_clk  = m_act && k >= 1 && k <= 16 * m_div && (((k - 1) / m_div) % 2 == 1);
    idx    = (k - 1) / (2 * m_div);
    if (idx > 7) idx = 7;
    e_mosi = e_busy ? m_tx[7 - idx] : 1'b1;
    if (e_done) m_rx = m_exp;
    seen_done = done;
    cs_smp    = sd_cs_n;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("sd_clk", sd_clk, e_clk);
    chk("sd_mosi", sd_mosi, e_mosi);
    chk("sd_cs_n", sd_cs_n, m_cs);
    chk("rx_byte", rx_byte, m_rx);
    if (!reset_n) begin
      m_act = 1'b0;
      m_rx  = 8'hFF;
      m_cs  = 1'b1;
      m_pv  = 1'b0;
    end else begin
      if (cs_wr && e_busy) begin
        m_pv   = 1'b1;
        m_pval = cs_val;
      end else if (cs_wr) begin
        m_cs = cs_val;
      end
      if (m_act && k == 16 * m_div + 1 && m_pv) begin
        m_cs = m_pval;
        m_pv = 1'b0;
      end
      if (start && !e_busy) begin
        m_act = 1'b1;
        m_st  = cyc;
        m_div = slow ? SLOW_DIV : FAST_DIV;
        m_tx  = tx_byte;
        case (miso_mode)
          0:       m_exp = tx_byte;
          1:       m_exp = 8'h00;
          2:       m_exp = rand_out;
          default: m_exp = card_out;
        endcase
      end
    end
    @(posedge clk_sys);
    #1;
    cyc++;
    start = 1'b0;
    cs_wr = 1'b0;
  endtask

  task automatic run_byte(input logic [7:0] tx, input logic sl, input int cs_with,
                          input int mid_cs, input bit mid_start,
                          output logic [7:0] rx, output int lat, output int ndone,
                          output logic cs_c1, output logic cs_pre, output logic cs_at);
    logic prev_cs;
    tx_byte = tx;
    slow    = sl;
    start   = 1'b1;
    if (cs_with >= 0) begin
      cs_wr  = 1'b1;
      cs_val = cs_with[0];
    end
    lat = -1; ndone = 0; cs_c1 = 1'bx; cs_pre = 1'bx; cs_at = 1'bx;
    prev_cs = sd_cs_n;
    cycle();
    for (int i = 1; i < 3000 && lat < 0; i++) begin
      if (i == 5 && mid_start) begin
        start   = 1'b1;
        tx_byte = 8'h00;
      end
      if (i == 7) slow = ~sl;
      if (i == 10 && mid_cs >= 0) begin
        cs_wr  = 1'b1;
        cs_val = mid_cs[0];
      end
      cycle();
      if (i == 1) cs_c1 = cs_smp;
      if (seen_done) begin
        ndone++;
        lat    = i;
        cs_at  = cs_smp;
        cs_pre = prev_cs;
      end
      prev_cs = cs_smp;
    end
    chk("done_timeout", lat >= 0, 1);
    rx = rx_byte;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (seen_done) ndone++;
    end
    slow = sl;
  endtask

  logic [7:0] rx, got, rb, tb_;
  int         lat, nd, r0, n;
  logic       c1, cpre, cat;
  logic [7:0] cmd0 [6];

  initial begin
    cmd0 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    repeat (3) cycle();
    chk("rst_rx_byte", rx_byte, 8'hFF);
    chk("rst_sd_mosi", sd_mosi, 1'b1);
    chk("rst_sd_cs_n", sd_cs_n, 1'b1);
    reset_n = 1'b1;
    cycle();

    // Fast loopback of A5.
    miso_mode = 0;
    r0 = slv_rises;
    run_byte(8'hA5, 1'b0, -1, -1, 1'b0, rx, lat, nd, c1, cpre, cat);
    chk("t1_latency", lat, 34);
    chk("t1_rx", rx, 8'hA5);
    chk("t1_mosi_bits", slv_in, 8'hA5);
    chk("t1_rises", slv_rises - r0, 8);

    // Slow byte with MISO held low.
    miso_mode = 1;
    run_byte(8'hFF, 1'b1, -1, -1, 1'b0, rx, lat, nd, c1, cpre, cat);
    chk("t2_latency", lat, 1026);
    chk("t2_rx", rx, 8'h00);
    chk("t2_mosi_bits", slv_in, 8'hFF);

    // CS select together with start, deselect mid-byte.
    miso_mode = 0;
    run_byte(8'h3C, 1'b0, 0, 1, 1'b0, rx, lat, nd, c1, cpre, cat);
    chk("t3_cs_low_early", c1, 1'b0);
    chk("t3_cs_before_done", cpre, 1'b0);
    chk("t3_cs_at_done", cat, 1'b1);

    // Start while busy is dropped.
    run_byte(8'hC3, 1'b0, -1, -1, 1'b1, rx, lat, nd, c1, cpre, cat);
    chk("t4_ndone", nd, 1);
    chk("t4_tx_kept", slv_in, 8'hC3);
    chk("t4_rx", rx, 8'hC3);

    // Reset in the middle of bit 4.
    r0 = slv_rises;
    tx_byte = 8'h5A; slow = 1'b0; start = 1'b1; cs_wr = 1'b1; cs_val = 1'b0;
    cycle();
    for (int i = 0; i < 200 && slv_rises - r0 < 4; i++) cycle();
    chk("t5_reach_bit4", slv_rises - r0, 4);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("t5_sd_clk", sd_clk, 1'b0);
    chk("t5_sd_mosi", sd_mosi, 1'b1);
    chk("t5_sd_cs_n", sd_cs_n, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rx_byte", rx_byte, 8'hFF);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (seen_done) n++;
    end
    chk("t5_no_done", n, 0);

    // CMD0 against the card responder, then poll for R1.
    miso_mode = 3;
    for (int j = 0; j < 6; j++)
      run_byte(cmd0[j], 1'b0, (j == 0) ? 0 : -1, -1, 1'b0, rx, lat, nd, c1, cpre, cat);
    got = 8'hFF;
    for (int p = 0; p < 8 && got == 8'hFF; p++) begin
      run_byte(8'hFF, 1'b0, -1, -1, 1'b0, rx, lat, nd, c1, cpre, cat);
      got = rx;
    end
    chk("t6_cmd0_r1", got, 8'h01);

    // Randomized traffic; the per-cycle model carries the checking.
    miso_mode = 2;
    for (int it = 0; it < 25; it++) begin
      rb = 8'($urandom);
      tb_ = 8'($urandom);
      rand_out = rb;
      run_byte(tb_, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)) - 1,
               int'($urandom_range(0, 2)) - 1, bit'($urandom_range(0, 1)),
               rx, lat, nd, c1, cpre, cat);
      chk("rand_rx", rx, rb);
      chk("rand_tx", slv_in, tb_);
      repeat ($urandom_range(0, 3)) cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
